mul_div_unit: RTL

Iterative signed 32×32 multiply / 32÷32 divide engine feeding the ZHI/ZLO result registers of the datapath. Operands arrive from the Y register (A) and the bus (B). The control unit starts an operation, stalls on `busy`, and latches the result into Z on `done`. This replaces the single-cycle MUL/DIV paths in the ALU with one add/sub per cycle.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mul_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions: operand width, multiply/divide op encodings
// and the state encoding of the iterative multiply/divide engine.
package cpu_pkg;

    localparam int WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (restoring, on
// magnitudes) engine. One shared WIDTH+1-bit adder/subtractor does one
// add/sub per cycle; results land in registered ZHI/ZLO feeds on DONE.
module mul_div_unit #(
    parameter int   WIDTH  = cpu_pkg::WIDTH,
    parameter logic OP_MUL = cpu_pkg::OP_MUL,
    parameter logic OP_DIV = cpu_pkg::OP_DIV
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    import cpu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    // Two's complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] val, input logic neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~val + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = val;
        end
        return res;
    endfunction

    md_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    // MUL: Booth high accumulator (signed, one guard bit). DIV: partial remainder.
    logic [WIDTH:0]   acc_hi_r;
    // MUL: remaining multiplier bits. DIV: dividend bits shifting into quotient.
    logic [WIDTH-1:0] acc_lo_r;
    logic             q_m1_r;
    // MUL: multiplicand. DIV: divisor magnitude.
    logic [WIDTH-1:0] opnd_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             dbz_pend_r;

    logic [WIDTH:0]   add_a_s;
    logic [WIDTH:0]   add_b_s;
    logic             add_sub_s;
    logic [WIDTH:0]   add_sum_s;

    // Shared adder/subtractor: operand selection depends on the iterating state.
    always_comb begin
        add_a_s   = {(WIDTH+1){1'b0}};
        add_b_s   = {(WIDTH+1){1'b0}};
        add_sub_s = 1'b0;
        case (state_r)
            MUL: begin
                add_a_s = acc_hi_r;
                // Booth pair {lo[0], q-1}: 01 adds A, 10 subtracts A, 00/11 pass through
                if (acc_lo_r[0] ^ q_m1_r) begin
                    add_b_s = {opnd_r[WIDTH-1], opnd_r};
                end else begin
                    add_b_s = {(WIDTH+1){1'b0}};
                end
                add_sub_s = acc_lo_r[0] & ~q_m1_r;
            end
            DIV: begin
                // Trial subtract on the remainder after shifting in the next dividend bit
                add_a_s   = {acc_hi_r[WIDTH-1:0], acc_lo_r[WIDTH-1]};
                add_b_s   = {1'b0, opnd_r};
                add_sub_s = 1'b1;
            end
            default: begin
                add_a_s   = {(WIDTH+1){1'b0}};
                add_b_s   = {(WIDTH+1){1'b0}};
                add_sub_s = 1'b0;
            end
        endcase
        add_sum_s = add_a_s + (add_b_s ^ {(WIDTH+1){add_sub_s}}) + {{WIDTH{1'b0}}, add_sub_s};
    end

    // Control FSM with the iteration datapath and all registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            acc_hi_r    <= {(WIDTH+1){1'b0}};
            acc_lo_r    <= {WIDTH{1'b0}};
            q_m1_r      <= 1'b0;
            opnd_r      <= {WIDTH{1'b0}};
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            dbz_pend_r  <= 1'b0;
            result_hi   <= {WIDTH{1'b0}};
            result_lo   <= {WIDTH{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        dbz_pend_r  <= 1'b0;
                        cnt_r       <= CNT_W'(WIDTH);
                        if (op == OP_DIV && opB == {WIDTH{1'b0}}) begin
                            // No iterations: one FIX cycle produces the divide-by-zero result
                            state_r    <= FIX;
                            dbz_pend_r <= 1'b1;
                            acc_lo_r   <= opA;
                        end else if (op == OP_DIV) begin
                            state_r  <= DIV;
                            acc_hi_r <= {(WIDTH+1){1'b0}};
                            acc_lo_r <= cond_neg(opA, opA[WIDTH-1]);
                            opnd_r   <= cond_neg(opB, opB[WIDTH-1]);
                            sign_a_r <= opA[WIDTH-1];
                            sign_b_r <= opB[WIDTH-1];
                        end else begin
                            state_r  <= MUL;
                            acc_hi_r <= {(WIDTH+1){1'b0}};
                            acc_lo_r <= opB;
                            q_m1_r   <= 1'b0;
                            opnd_r   <= opA;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                MUL: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        // Arithmetic shift of {hi, lo, q-1} right by one after the add
                        acc_hi_r <= {add_sum_s[WIDTH], add_sum_s[WIDTH:1]};
                        acc_lo_r <= {add_sum_s[0], acc_lo_r[WIDTH-1:1]};
                        q_m1_r   <= acc_lo_r[0];
                        cnt_r    <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result_hi <= acc_hi_r[WIDTH-1:0];
                        result_lo <= acc_lo_r;
                    end
                end
                DIV: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        // Keep the difference when non-negative, otherwise restore
                        if (!add_sum_s[WIDTH]) begin
                            acc_hi_r <= add_sum_s;
                        end else begin
                            acc_hi_r <= add_a_s;
                        end
                        acc_lo_r <= {acc_lo_r[WIDTH-2:0], ~add_sum_s[WIDTH]};
                        cnt_r    <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    state_r <= DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    if (dbz_pend_r) begin
                        result_hi   <= acc_lo_r;
                        result_lo   <= {WIDTH{1'b1}};
                        div_by_zero <= 1'b1;
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend sign
                        result_lo <= cond_neg(acc_lo_r, sign_a_r ^ sign_b_r);
                        result_hi <= cond_neg(acc_hi_r[WIDTH-1:0], sign_a_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
